// File: rtl/mux_bin_pipe_pkg.sv
// Shared helpers for mux_bin_pipe: tree geometry (levels, padded size) and latency.
package mux_bin_pipe_pkg;

    function automatic int ipow(input int base, input int exp);
        int p = 1;
        for (int k = 0; k < exp; k++) p = p * base;
        return p;
    endfunction

    // Number of SPLIT-ary levels needed to consume every select bit.
    function automatic int calc_levels(input int width, input int split);
        int wl;
        int sl;
        wl = $clog2(width);
        sl = $clog2(split);
        return (wl + sl - 1) / sl;
    endfunction

    function automatic int calc_power(input int width, input int split);
        return ipow(split, calc_levels(width, split));
    endfunction

    // Register-stage count of a REGS mask, i.e. the pipeline latency.
    function automatic int popcount(input logic [31:0] mask);
        int n = 0;
        for (int k = 0; k < 32; k++) n = n + int'(mask[k]);
        return n;
    endfunction

endpackage

// File: rtl/mux_bin_pipe_stage.sv
// One SPLIT-ary level of the select tree, optionally followed by a
// valid/ready register stage carrying data, remaining select bits and err.
module mux_bin_pipe_stage #(
    parameter type DAT_T     = logic [7:0],
    parameter int  N_IN      = 2,
    parameter int  SPLIT     = 2,
    parameter int  SEL_W     = 1,
    parameter bit  REG       = 1'b1,
    localparam int N_OUT     = N_IN / SPLIT,
    localparam int SPLIT_LOG = $clog2(SPLIT)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_vld,
    output logic             in_rdy,
    input  DAT_T             in_ary [N_IN],
    input  logic [SEL_W-1:0] in_sel,
    input  logic             in_err,
    output logic             out_vld,
    input  logic             out_rdy,
    output DAT_T             out_ary [N_OUT],
    output logic [SEL_W-1:0] out_sel,
    output logic             out_err
);

    DAT_T                 mux_ary [N_OUT];
    logic [SEL_W-1:0]     mux_sel;
    logic [SPLIT_LOG-1:0] digit;

    assign digit   = in_sel[SPLIT_LOG-1:0];
    assign mux_sel = in_sel >> SPLIT_LOG;

    // NOTE: every element is assigned on every pass, so this stays purely combinational.
    always_comb begin
        for (int j = 0; j < N_OUT; j++) begin
            mux_ary[j] = in_ary[j * SPLIT + int'(digit)];
        end
    end

    if (REG) begin : g_reg
        logic             vld_q;
        DAT_T             ary_q [N_OUT];
        logic [SEL_W-1:0] sel_q;
        logic             err_q;

        assign in_rdy = !vld_q || out_rdy;

        // NOTE: the data registers are reset as well, because a registered last
        // level must present o_dat=0 and o_err=0 straight out of reset.
        always_ff @(posedge clk) begin
            if (rst) begin
                vld_q <= 1'b0;
                sel_q <= '0;
                err_q <= 1'b0;
                for (int j = 0; j < N_OUT; j++) ary_q[j] <= '0;
            end else if (in_rdy) begin
                vld_q <= in_vld;
                // Bubbles only clear the valid bit; the payload keeps its last value.
                if (in_vld) begin
                    sel_q <= mux_sel;
                    err_q <= in_err;
                    for (int j = 0; j < N_OUT; j++) ary_q[j] <= mux_ary[j];
                end
            end
        end

        assign out_vld = vld_q;
        assign out_ary = ary_q;
        assign out_sel = sel_q;
        assign out_err = err_q;
    end else begin : g_comb
        assign in_rdy  = out_rdy;
        assign out_vld = in_vld;
        assign out_ary = mux_ary;
        assign out_sel = mux_sel;
        assign out_err = in_err;
    end

endmodule

// File: rtl/mux_bin_pipe.sv
// Pipelined valid/ready binary-select mux tree with out-of-range detection.
// Define MUX_BIN_PIPE_SKID_EN to add a 2-entry output skid buffer.
module mux_bin_pipe
    import mux_bin_pipe_pkg::*;
#(
    parameter type DAT_T = logic [8-1:0],
    parameter int  WIDTH = 32,
    parameter int  SPLIT = 2,
    localparam int WIDTH_LOG = $clog2(WIDTH),
    localparam int SPLIT_LOG = $clog2(SPLIT),
    localparam int LEVELS    = calc_levels(WIDTH, SPLIT),
    localparam int POWER     = calc_power(WIDTH, SPLIT),
    parameter logic [LEVELS-1:0] REGS = '1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_vld,
    output logic                 i_rdy,
    input  logic [WIDTH_LOG-1:0] i_bin,
    input  DAT_T                 i_ary [WIDTH],
    output logic                 o_vld,
    input  logic                 o_rdy,
    output DAT_T                 o_dat,
    output logic                 o_err
);

    localparam int SEL_W = LEVELS * SPLIT_LOG;

    DAT_T                         pad_ary [POWER];
    logic [LEVELS:0]              vld_b;
    logic [LEVELS:0]              rdy_b;
    logic [LEVELS:0]              err_b;
    logic [LEVELS:0][SEL_W-1:0]   sel_b;
    logic                         last_rdy;
    DAT_T                         last_dat;

    // Selects in [WIDTH, POWER) land on these zero entries, so o_dat is 0 for them.
    for (genvar i = 0; i < POWER; i++) begin : g_pad
        if (i < WIDTH) begin : g_dat
            assign pad_ary[i] = i_ary[i];
        end else begin : g_zero
            assign pad_ary[i] = '0;
        end
    end

    assign vld_b[0] = i_vld;
    assign i_rdy    = rdy_b[0];
    assign sel_b[0] = SEL_W'(i_bin);
    assign err_b[0] = {1'b0, i_bin} >= (WIDTH_LOG + 1)'(WIDTH);
    assign rdy_b[LEVELS] = last_rdy;

    for (genvar k = 0; k < LEVELS; k++) begin : g_lvl
        localparam int N_IN  = POWER / ipow(SPLIT, k);
        localparam int N_OUT = N_IN / SPLIT;

        DAT_T ary_in  [N_IN];
        DAT_T ary_out [N_OUT];

        if (k == 0) begin : g_head
            assign ary_in = pad_ary;
        end else begin : g_link
            assign ary_in = g_lvl[k-1].ary_out;
        end

        mux_bin_pipe_stage #(
            .DAT_T (DAT_T),
            .N_IN  (N_IN),
            .SPLIT (SPLIT),
            .SEL_W (SEL_W),
            .REG   (REGS[k])
        ) u_stage (
            .clk     (clk),
            .rst     (rst),
            .in_vld  (vld_b[k]),
            .in_rdy  (rdy_b[k]),
            .in_ary  (ary_in),
            .in_sel  (sel_b[k]),
            .in_err  (err_b[k]),
            .out_vld (vld_b[k+1]),
            .out_rdy (rdy_b[k+1]),
            .out_ary (ary_out),
            .out_sel (sel_b[k+1]),
            .out_err (err_b[k+1])
        );
    end

    assign last_dat = g_lvl[LEVELS-1].ary_out[0];

`ifdef MUX_BIN_PIPE_SKID_EN
    typedef struct packed {
        DAT_T dat;
        logic err;
    } skid_t;

    skid_t      skid_q [2];
    logic [1:0] skid_cnt_q;
    skid_t      in_pl;
    skid_t      out_pl;
    logic       push;
    logic       pop;

    // Ready toward the tree depends only on the fill count, never on o_rdy.
    assign last_rdy = (skid_cnt_q != 2'd2);
    assign in_pl    = '{dat: last_dat, err: err_b[LEVELS]};
    // An empty buffer is bypassed, so latency is unchanged while o_rdy stays high.
    assign out_pl   = (skid_cnt_q == 2'd0) ? in_pl : skid_q[0];
    assign o_vld    = vld_b[LEVELS] || (skid_cnt_q != 2'd0);
    assign o_dat    = out_pl.dat;
    assign o_err    = out_pl.err;
    assign pop      = o_rdy && (skid_cnt_q != 2'd0);
    assign push     = vld_b[LEVELS] && last_rdy && !(o_rdy && skid_cnt_q == 2'd0);

    always_ff @(posedge clk) begin
        if (rst) begin
            skid_cnt_q <= 2'd0;
            skid_q[0]  <= '0;
            skid_q[1]  <= '0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    skid_q[skid_cnt_q[0]] <= in_pl;
                    skid_cnt_q            <= skid_cnt_q + 2'd1;
                end
                2'b01: begin
                    skid_q[0]  <= skid_q[1];
                    skid_cnt_q <= skid_cnt_q - 2'd1;
                end
                2'b11: begin
                    // Only reachable with one entry held: replace the head in place.
                    skid_q[0] <= in_pl;
                end
                default: ;
            endcase
        end
    end
`else
    assign last_rdy = o_rdy;
    assign o_vld    = vld_b[LEVELS];
    assign o_dat    = last_dat;
    assign o_err    = err_b[LEVELS];
`endif

endmodule
